up_timer: RTL and testbench

Programmable up-counting timer: counts from 0 to a latched terminal value `limit` and pulses `done` on the terminal step. It supports one-shot and periodic modes with pause/resume. It complements the free-running down counter in the sequential library by providing a controlled up-count with a start/stop handshake. It sits between control logic and any block needing timed events: debouncers, timeouts, periodic strobes.

---
 rtl/up_timer_pkg.sv | 13 +
 rtl/up_timer_prescaler.sv | 31 +++
 rtl/up_timer.sv | 116 +++++++++++
 tb/tb_up_timer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/up_timer_pkg.sv
// Shared types and constants for the up_timer block.
package up_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/up_timer_prescaler.sv
// Step divider: tick is high on every (div+1)-th advanced cycle.
// The divide value is captured on clear, together with the phase reset.
module up_timer_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] div_q;
  logic [W-1:0] cnt;

  assign tick = (cnt == div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (clear) begin
      div_q <= div;
      cnt   <= '0;
    end else if (advance) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/up_timer.sv
// Programmable up-counting timer, one-shot or periodic, with pause/resume.
// Define UP_TIMER_PRESCALE_EN to compile in the step prescaler.
module up_timer
  import up_timer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  // start/stop are single-cycle requests, acted on at the edge where they are
  // seen high; there is no ready back-pressure. In RUN/PAUSE stop beats start,
  // in IDLE start beats stop.

  state_t           state, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             per_q, per_d;
  logic             done_d;
  logic             tick;
  logic             launch;
  logic             advance;

  assign launch  = (state == IDLE) && start;
  assign advance = (state == RUN) && !stop && enable;

`ifdef UP_TIMER_PRESCALE_EN
  up_timer_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .advance (advance),
    .div     (prescale),
    .tick    (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      lim_q <= '0;
      per_q <= MODE_ONESHOT;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      lim_q <= lim_d;
      per_q <= per_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    lim_d   = lim_q;
    per_d   = per_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          lim_d   = limit;
          per_d   = periodic;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (advance && tick) begin
          if (count != lim_q) begin
            count_d = count + 1'b1;
          end else begin
            // Terminal step: one-shot parks at limit, periodic restarts at 0.
            done_d = 1'b1;
            if (per_q == MODE_PERIODIC) begin
              count_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_up_timer.sv
// Directed bench for up_timer: a vector table for the main flows plus
// hand-written sequences for limit edge cases, enable gating, reset and prescaling.
module tb_up_timer;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic                  start;
  logic                  stop;
  logic                  periodic;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             start;
    logic             stop;
    logic             en;
    logic             per;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] exp_count;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  up_timer #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input int s, input int p, input int e, input int per,
                         input int l, input int c, input int b, input int d);
    vec_t v;
    v.start     = s[0];
    v.stop      = p[0];
    v.en        = e[0];
    v.per       = per[0];
    v.lim       = l[WIDTH-1:0];
    v.exp_count = c[WIDTH-1:0];
    v.exp_busy  = b[0];
    v.exp_done  = d[0];
    vecs.push_back(v);
  endtask

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic drive(input int s, input int p, input int e, input int per,
                       input int l);
    start    = s[0];
    stop     = p[0];
    enable   = e[0];
    periodic = per[0];
    limit    = l[WIDTH-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] c,
                       input logic b, input logic d);
    n_checks++;
    if (count !== c || busy !== b || done !== d) begin
      n_fail++;
      $display("FAIL %s: count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
               name, count, busy, done, c, b, d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    limit    = '0;
    prescale = '0;

    //        start stop en per lim | count busy done
    // one-shot limit 5, then stop ignored in IDLE
    add_vec(1, 0, 1, 0, 5,  0, 1, 0);
    add_vec(0, 0, 1, 0, 5,  1, 1, 0);
    add_vec(0, 0, 1, 0, 5,  2, 1, 0);
    add_vec(0, 0, 1, 0, 5,  3, 1, 0);
    add_vec(0, 0, 1, 0, 5,  4, 1, 0);
    add_vec(0, 0, 1, 0, 5,  5, 1, 0);
    add_vec(0, 0, 1, 0, 5,  5, 0, 1);
    add_vec(0, 0, 1, 0, 5,  5, 0, 0);
    add_vec(0, 1, 1, 0, 9,  5, 0, 0);
    // pause at count 2, resume to completion
    add_vec(1, 0, 1, 0, 4,  0, 1, 0);
    add_vec(0, 0, 1, 0, 4,  1, 1, 0);
    add_vec(0, 0, 1, 0, 4,  2, 1, 0);
    add_vec(0, 1, 1, 0, 4,  2, 1, 0);
    add_vec(0, 0, 1, 0, 4,  2, 1, 0);
    add_vec(1, 0, 1, 0, 4,  2, 1, 0);
    add_vec(0, 0, 1, 0, 4,  3, 1, 0);
    add_vec(0, 0, 1, 0, 4,  4, 1, 0);
    add_vec(0, 0, 1, 0, 4,  4, 0, 1);
    // pause then abort; no done
    add_vec(1, 0, 1, 0, 4,  0, 1, 0);
    add_vec(0, 0, 1, 0, 4,  1, 1, 0);
    add_vec(0, 1, 1, 0, 4,  1, 1, 0);
    add_vec(0, 1, 1, 0, 4,  1, 0, 0);
    // start+stop together: start wins in IDLE, stop wins in RUN
    add_vec(1, 1, 1, 0, 2,  0, 1, 0);
    add_vec(1, 1, 1, 0, 2,  0, 1, 0);
    add_vec(0, 1, 1, 0, 2,  0, 0, 0);
    // stop on the terminal step suppresses done
    add_vec(1, 0, 1, 0, 1,  0, 1, 0);
    add_vec(0, 0, 1, 0, 1,  1, 1, 0);
    add_vec(0, 1, 1, 0, 1,  1, 1, 0);
    add_vec(1, 0, 1, 0, 1,  1, 1, 0);
    add_vec(0, 0, 1, 0, 1,  1, 0, 1);
    // periodic limit 3; limit changed mid-run is ignored
    add_vec(1, 0, 1, 1, 3,  0, 1, 0);
    add_vec(0, 0, 1, 0, 3,  1, 1, 0);
    add_vec(0, 0, 1, 0, 7,  2, 1, 0);
    add_vec(0, 0, 1, 0, 7,  3, 1, 0);
    add_vec(0, 0, 1, 0, 1,  0, 1, 1);
    add_vec(0, 0, 1, 0, 1,  1, 1, 0);
    add_vec(0, 0, 1, 0, 1,  2, 1, 0);
    add_vec(0, 0, 1, 0, 1,  3, 1, 0);
    add_vec(0, 0, 1, 0, 1,  0, 1, 1);
    add_vec(0, 1, 1, 0, 1,  0, 1, 0);
    add_vec(0, 1, 1, 0, 1,  0, 0, 0);

    do_reset();
    check("reset", 4'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(int'(vecs[i].start), int'(vecs[i].stop), int'(vecs[i].en),
            int'(vecs[i].per), int'(vecs[i].lim));
      check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
            vecs[i].exp_done);
    end

    // limit 0 periodic: done every enabled cycle, count stays 0
    drive(1, 0, 1, 1, 0);
    check("lim0_start", 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      check($sformatf("lim0_step%0d", i), 4'd0, 1'b1, 1'b1);
    end
    drive(0, 0, 0, 0, 0);
    check("lim0_disabled", 4'd0, 1'b1, 1'b0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    check("lim0_abort", 4'd0, 1'b0, 1'b0);

    // limit 15 one-shot: reaches 15 without wrapping
    drive(1, 0, 1, 0, 15);
    check("lim15_start", 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      drive(0, 0, 1, 0, 15);
      check($sformatf("lim15_c%0d", i), 4'(i), 1'b1, 1'b0);
    end
    drive(0, 0, 1, 0, 15);
    check("lim15_done", 4'd15, 1'b0, 1'b1);
    drive(0, 0, 1, 0, 15);
    check("lim15_hold", 4'd15, 1'b0, 1'b0);

    // 50% enable, limit 4: done on the 5th enabled cycle; limit churn ignored
    begin
      int en_steps;
      en_steps = 0;
      drive(1, 0, 1, 0, 4);
      check("en_start", 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
        drive(0, 0, i % 2, 0, i);
        if (i % 2 == 1) en_steps++;
        check($sformatf("en_cyc%0d", i), 4'((en_steps > 4) ? 4 : en_steps),
              (en_steps < 5) ? 1'b1 : 1'b0, (i % 2 == 1 && en_steps == 5));
      end
    end

    // reset mid-run and reset on a would-be terminal step
    drive(1, 0, 1, 0, 9);
    drive(0, 0, 1, 0, 9);
    drive(0, 0, 1, 0, 9);
    check("pre_reset", 4'd2, 1'b1, 1'b0);
    reset = 1'b1;
    drive(0, 0, 1, 0, 9);
    reset = 1'b0;
    check("mid_reset", 4'd0, 1'b0, 1'b0);
    drive(1, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    check("pre_term_reset", 4'd1, 1'b1, 1'b0);
    reset = 1'b1;
    drive(0, 0, 1, 0, 1);
    reset = 1'b0;
    check("term_reset", 4'd0, 1'b0, 1'b0);

`ifdef UP_TIMER_PRESCALE_EN
    // prescale 2, limit 1: step every 3 cycles, done 6 cycles after start
    prescale = 4'd2;
    drive(1, 0, 1, 0, 1);
    prescale = 4'd0;
    check("ps_start", 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 1, 0, 1);
      check($sformatf("ps_cyc%0d", i), (i >= 3) ? 4'd1 : 4'd0,
            (i < 6) ? 1'b1 : 1'b0, (i == 6));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
